syrup_memory_np: RTL and testbench
==================================

Name: syrup_memory_np

Overview:
- Parametrised N-port abstract memory that replaces the fixed 1P..5P family with one block.
- N logical ports are emulated on a single physical storage array by serialising all accesses of one user step.
- STALL freezes the user clock domain while the sequence runs.
- Sits between user logic and the storage array; DOMAIN/ID are carried unchanged for the mapping tools.

Parameters:
- DOMAIN, "undefined", clock-domain tag for tooling; no RTL effect.
- ID, 0, instance identifier for tooling; no RTL effect.
- NUM_PORTS, 2, number of logical ports, legal 1..8.
- ADDR_WIDTH, 10, word address width; array depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width, a multiple of 8.
- BYTE_ENABLE, 0, 1 = honour BE on writes; 0 = full-word writes, BE ignored.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse: latch all port requests for this user step.
- ADDR  in  NUM_PORTS*ADDR_WIDTH  port i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
- D  in  NUM_PORTS*DATA_WIDTH  write data, packed per port.
- WE  in  NUM_PORTS  per-port write enable.
- RE  in  NUM_PORTS  per-port read enable.
- BE  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- Q  out  NUM_PORTS*DATA_WIDTH  per-port read data, packed.
- STALL  out  1  high while serialising; user domain must hold.
- OVERRUN  out  1  sticky; set when START arrives while STALL=1.

Behaviour:
- Reset (sync, RST=1 at posedge): state IDLE, STALL=0, OVERRUN=0, all Q=0, latched requests cleared. Array contents are not reset. A reset mid-SERVE aborts the sequence; writes already executed persist and pending writes are dropped.
- States: IDLE, SERVE.
- IDLE:
  - On START=1, latch ADDR/D/WE/RE/BE for all ports and form active mask act[i]=WE[i]|RE[i].
  - act==0: stay IDLE, STALL stays 0, Q unchanged.
  - Otherwise go to SERVE with cur = lowest set bit of act.
- SERVE:
  - One access per cycle, strictly ascending port index.
  - Inactive ports are skipped in zero cycles, via a priority encoder over the remaining mask.
  - After the highest active port is served, return to IDLE.
- Timing: START at cycle t with k active ports gives STALL=1 for cycles t+1..t+k. At t+k+1, STALL=0 and every Q and array update is final.
- Per access on port i:
  - If RE[i]: Q_i <= array[ADDR_i] (read-first, old data).
  - Then, if WE[i]: write array[ADDR_i]. With BYTE_ENABLE=1, byte b is written only if BE_i[b].
  - A port with both RE and WE returns the pre-write word.
- Ordering: a higher-index port observes writes of lower-index ports in the same step. Two writes to the same address: the highest index wins.
- Q_i for ports without RE holds its previous value. Q is guaranteed only while STALL=0.
- START while STALL=1: ignored and sets OVERRUN (cleared only by RST). START in the same cycle as the final SERVE access is also an overrun.
- NUM_PORTS=1: degenerates to 1-cycle stall per active step.
- Storage: write is registered; read is combinational within the SERVE cycle (maps to distributed RAM or a read-first BRAM wrapper).

Decomposition:
- Shared package syrup_pkg:
  - state encoding localparams SYRUP_IDLE, SYRUP_SERVE;
  - helper function for clog2 of NUM_PORTS;
  - maximum port count constant (8).
- Sub-module syrup_next_port (NUM_PORTS param): takes the remaining mask and returns the lowest set index plus a last flag.
- Storage array stays inline in syrup_memory_np.

Test Plan:
1. NUM_PORTS=2: step 1, port0 WE addr 5 D=0xDEADBEEF. Step 2, port1 RE addr 5 -> STALL high exactly 1 cycle each step; Q1=0xDEADBEEF.
2. Same step: port0 WE addr 3 D=0x11, port1 RE addr 3 -> STALL 2 cycles; Q1=0x11 (lower index visible).
3. Port with RE+WE addr 7 (old 0xAA, D=0xBB) -> Q=0xAA; next-step read returns 0xBB.
4. BYTE_ENABLE=1: word 0xFFFFFFFF, then WE with BE=4'b0101 D=0x00000000 -> read 0xFF00FF00.
5. NUM_PORTS=4, only ports 1 and 3 active -> STALL exactly 2 cycles. START during STALL -> OVERRUN=1 and step not re-executed. Steps with act==0 -> STALL never rises.
6. RST asserted in 2nd SERVE cycle of a 3-access step -> next cycle STALL=0, Q=0, OVERRUN=0. First write is present on read-back; third write is absent.

Source files
------------

// File: rtl/syrup_pkg.sv
// Shared definitions for the N-port serialised memory: FSM encoding,
// port-count limits and the index-width helper.
package syrup_pkg;

    // Largest supported number of logical ports.
    localparam int SYRUP_MAX_PORTS = 8;

    // Sequencer states: IDLE waits for START, SERVE performs one access per cycle.
    typedef enum logic {
        SYRUP_IDLE  = 1'b0,
        SYRUP_SERVE = 1'b1
    } syrup_state_e;

    // Width of a port index for n ports; at least one bit so NUM_PORTS=1 still
    // yields a legal vector. Covers up to SYRUP_MAX_PORTS.
    function automatic int syrup_idx_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i <= 3; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/syrup_next_port.sv
// Priority encoder over the remaining-access mask: returns the lowest pending
// port index and flags whether it is the last pending access of the step.
module syrup_next_port
    import syrup_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = syrup_idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] mask,
    output logic [IDX_W-1:0]     idx,
    output logic                 last
);

    // Lowest set bit wins; last is true when no pending bit lies above it.
    always_comb begin
        idx  = '0;
        last = 1'b1;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mask[i] && (i > int'(idx))) begin
                last = 1'b0;
            end else begin
                last = last;
            end
        end
    end

endmodule

// File: rtl/syrup_memory_np.sv
// N-port abstract memory built on one physical array. All requests of a user
// step are latched on START and replayed one per cycle in ascending port
// order while STALL holds the user domain. Reads are read-first per access;
// lower-index writes are visible to higher-index ports in the same step.
module syrup_memory_np
    import syrup_pkg::*;
#(
    parameter string DOMAIN      = "undefined",
    parameter int    ID          = 0,
    parameter int    NUM_PORTS   = 2,
    parameter int    ADDR_WIDTH  = 10,
    parameter int    DATA_WIDTH  = 32,
    parameter int    BYTE_ENABLE = 0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              START,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   ADDR,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   D,
    input  logic [NUM_PORTS-1:0]              WE,
    input  logic [NUM_PORTS-1:0]              RE,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] BE,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   Q,
    output logic                              STALL,
    output logic                              OVERRUN
);

    localparam int IDX_W = syrup_idx_width(NUM_PORTS);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    syrup_state_e                      state_r;
    syrup_state_e                      state_s;

    logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_r;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   d_r;
    logic [NUM_PORTS-1:0]              we_r;
    logic [NUM_PORTS-1:0]              re_r;
    logic [NUM_PORTS*NB-1:0]           be_r;
    logic [NUM_PORTS-1:0]              rem_r;
    logic [NUM_PORTS*DATA_WIDTH-1:0]   q_r;
    logic                              overrun_r;

    logic [DATA_WIDTH-1:0]             mem_r [0:DEPTH-1];

    logic [NUM_PORTS-1:0]              act_s;
    logic [IDX_W-1:0]                  cur_s;
    logic                              last_s;
    logic                              serve_s;
    logic                              latch_s;
    logic                              overrun_set_s;
    logic [ADDR_WIDTH-1:0]             addr_cur_s;
    logic [DATA_WIDTH-1:0]             d_cur_s;
    logic [NB-1:0]                     be_cur_s;
    logic                              we_cur_s;
    logic                              re_cur_s;
    logic [DATA_WIDTH-1:0]             rdata_s;
    logic [DATA_WIDTH-1:0]             wdata_s;

    // Picks the next pending port from what is left of this step.
    syrup_next_port #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_next_port (
        .mask (rem_r),
        .idx  (cur_s),
        .last (last_s)
    );

    // Step control: accept a step only from IDLE with at least one active port;
    // any START seen while serving is an overrun and is otherwise ignored.
    always_comb begin
        act_s         = WE | RE;
        serve_s       = 1'b0;
        latch_s       = 1'b0;
        overrun_set_s = 1'b0;
        if (state_r == SYRUP_SERVE) begin
            serve_s       = 1'b1;
            overrun_set_s = START;
        end else begin
            latch_s = START & (|act_s);
        end
    end

    // Selects the latched request of the port being served this cycle.
    always_comb begin
        addr_cur_s = addr_r[int'(cur_s)*ADDR_WIDTH +: ADDR_WIDTH];
        d_cur_s    = d_r[int'(cur_s)*DATA_WIDTH +: DATA_WIDTH];
        be_cur_s   = be_r[int'(cur_s)*NB +: NB];
        we_cur_s   = we_r[cur_s];
        re_cur_s   = re_r[cur_s];
        rdata_s    = mem_r[addr_cur_s];
    end

    // Write word: with byte enables, unselected bytes keep the stored value.
    always_comb begin
        wdata_s = d_cur_s;
        if (BYTE_ENABLE != 0) begin
            for (int b = 0; b < NB; b++) begin
                if (be_cur_s[b]) begin
                    wdata_s[b*8 +: 8] = d_cur_s[b*8 +: 8];
                end else begin
                    wdata_s[b*8 +: 8] = rdata_s[b*8 +: 8];
                end
            end
        end else begin
            wdata_s = d_cur_s;
        end
    end

    // Next-state logic: leave SERVE right after the highest active port.
    always_comb begin
        state_s = state_r;
        case (state_r)
            SYRUP_IDLE: begin
                if (latch_s) begin
                    state_s = SYRUP_SERVE;
                end else begin
                    state_s = SYRUP_IDLE;
                end
            end
            SYRUP_SERVE: begin
                if (last_s) begin
                    state_s = SYRUP_IDLE;
                end else begin
                    state_s = SYRUP_SERVE;
                end
            end
            default: state_s = SYRUP_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= SYRUP_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, remaining-access mask, read-data and sticky overrun flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_r    <= '0;
            d_r       <= '0;
            we_r      <= '0;
            re_r      <= '0;
            be_r      <= '0;
            rem_r     <= '0;
            q_r       <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (latch_s) begin
                addr_r <= ADDR;
                d_r    <= D;
                we_r   <= WE;
                re_r   <= RE;
                be_r   <= BE;
                rem_r  <= act_s;
            end else if (serve_s) begin
                rem_r[cur_s] <= 1'b0;
                if (re_cur_s) begin
                    q_r[int'(cur_s)*DATA_WIDTH +: DATA_WIDTH] <= rdata_s;
                end
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Storage write port: one word per SERVE cycle; a reset cycle drops it.
    always_ff @(posedge CLK) begin
        if (!RST && serve_s && we_cur_s) begin
            mem_r[addr_cur_s] <= wdata_s;
        end
    end

    assign Q       = q_r;
    assign STALL   = (state_r == SYRUP_SERVE);
    assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_syrup_memory_np.sv
// Directed bench for syrup_memory_np: a 2-port full-word instance and a
// 4-port byte-enable instance. Expected read data is queued when a step is
// set up and compared once the step has finished stalling.
module tb_syrup_memory_np;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_b;
        int          port;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // Instance A: 2 ports, full-word writes
    logic         a_rst, a_start, a_stall, a_overrun;
    logic [15:0]  a_addr;
    logic [63:0]  a_d, a_q;
    logic [1:0]   a_we, a_re;
    logic [7:0]   a_be;

    // Instance B: 4 ports, byte enables honoured
    logic         b_rst, b_start, b_stall, b_overrun;
    logic [31:0]  b_addr;
    logic [127:0] b_d, b_q;
    logic [3:0]   b_we, b_re;
    logic [15:0]  b_be;

    syrup_memory_np #(.DOMAIN("tb_a"), .ID(1), .NUM_PORTS(2), .ADDR_WIDTH(8),
                      .DATA_WIDTH(32), .BYTE_ENABLE(0)) u_dut_a (
        .CLK(clk), .RST(a_rst), .START(a_start), .ADDR(a_addr), .D(a_d),
        .WE(a_we), .RE(a_re), .BE(a_be), .Q(a_q), .STALL(a_stall),
        .OVERRUN(a_overrun));

    syrup_memory_np #(.DOMAIN("tb_b"), .ID(2), .NUM_PORTS(4), .ADDR_WIDTH(8),
                      .DATA_WIDTH(32), .BYTE_ENABLE(1)) u_dut_b (
        .CLK(clk), .RST(b_rst), .START(b_start), .ADDR(b_addr), .D(b_d),
        .WE(b_we), .RE(b_re), .BE(b_be), .Q(b_q), .STALL(b_stall),
        .OVERRUN(b_overrun));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_q(input bit is_b, input int port, input logic [31:0] v, input string tag);
        exp_t e;
        e.is_b = is_b;
        e.port = port;
        e.exp  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_b) obs = b_q[e.port*32 +: 32];
            else        obs = a_q[e.port*32 +: 32];
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic a_idle();
        a_we = '0; a_re = '0; a_be = '0; a_addr = '0; a_d = '0;
    endtask

    task automatic b_idle();
        b_we = '0; b_re = '0; b_be = '0; b_addr = '0; b_d = '0;
    endtask

    task automatic a_port(input int p, input logic we, input logic re,
                          input logic [7:0] addr, input logic [31:0] d);
        a_we[p] = we; a_re[p] = re;
        a_addr[p*8 +: 8] = addr; a_d[p*32 +: 32] = d;
    endtask

    task automatic b_port(input int p, input logic we, input logic re,
                          input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
        b_we[p] = we; b_re[p] = re;
        b_addr[p*8 +: 8] = addr; b_d[p*32 +: 32] = d; b_be[p*4 +: 4] = be;
    endtask

    // One-cycle START, then count STALL cycles (bounded).
    task automatic a_step(output int n);
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (a_stall === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a_idle();
    endtask

    task automatic b_step(output int n);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 0;
        while (b_stall === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        b_idle();
    endtask

    initial begin
        int n;
        a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        a_idle(); b_idle();
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;

        // Reset state
        chk("rst_a_stall", 32'(a_stall), 32'd0);
        chk("rst_a_overrun", 32'(a_overrun), 32'd0);
        chk("rst_a_q0", a_q[31:0], 32'd0);
        chk("rst_a_q1", a_q[63:32], 32'd0);
        chk("rst_b_stall", 32'(b_stall), 32'd0);

        // Write in one step, read back in the next
        a_port(0, 1'b1, 1'b0, 8'd5, 32'hDEADBEEF);
        a_step(n); chk("t1_wr_stall", n, 32'd1);
        a_port(1, 1'b0, 1'b1, 8'd5, 32'd0);
        expect_q(1'b0, 1, 32'hDEADBEEF, "t1_q1");
        a_step(n); chk("t1_rd_stall", n, 32'd1);
        drain();

        // Lower-index write visible to higher-index read in the same step
        a_port(0, 1'b1, 1'b0, 8'd3, 32'h11);
        a_port(1, 1'b0, 1'b1, 8'd3, 32'd0);
        expect_q(1'b0, 1, 32'h11, "t2_q1");
        expect_q(1'b0, 0, 32'h0, "t2_q0_hold");
        a_step(n); chk("t2_stall", n, 32'd2);
        drain();

        // Read+write on one port returns the old word
        a_port(1, 1'b1, 1'b0, 8'd7, 32'hAA);
        a_step(n);
        a_port(0, 1'b1, 1'b1, 8'd7, 32'hBB);
        expect_q(1'b0, 0, 32'hAA, "t3_rw_old");
        a_step(n); chk("t3_rw_stall", n, 32'd1);
        drain();
        a_port(0, 1'b0, 1'b1, 8'd7, 32'd0);
        expect_q(1'b0, 0, 32'hBB, "t3_rd_new");
        expect_q(1'b0, 1, 32'h11, "t3_q1_hold");
        a_step(n);
        drain();

        // Two writes to the same address: higher index wins
        a_port(0, 1'b1, 1'b0, 8'd9, 32'h1);
        a_port(1, 1'b1, 1'b0, 8'd9, 32'h2);
        a_step(n); chk("t3_ww_stall", n, 32'd2);
        a_port(0, 1'b0, 1'b1, 8'd9, 32'd0);
        expect_q(1'b0, 0, 32'h2, "t3_ww_win");
        a_step(n);
        drain();

        // Empty step: no stall, Q untouched
        a_step(n); chk("t5_empty_stall", n, 32'd0);
        expect_q(1'b0, 0, 32'h2, "t5_empty_q0");
        expect_q(1'b0, 1, 32'h11, "t5_empty_q1");
        drain();
        chk("a_overrun_clear", 32'(a_overrun), 32'd0);

        // Byte enables
        b_port(2, 1'b1, 1'b0, 8'd4, 32'hFFFFFFFF, 4'hF);
        b_step(n);
        b_port(2, 1'b1, 1'b0, 8'd4, 32'h00000000, 4'b0101);
        b_step(n);
        b_port(0, 1'b0, 1'b1, 8'd4, 32'd0, 4'h0);
        expect_q(1'b1, 0, 32'hFF00FF00, "t4_be");
        b_step(n);
        drain();

        // Sparse mask: ports 1 and 3 only
        b_port(1, 1'b1, 1'b0, 8'd10, 32'h1234, 4'hF);
        b_port(3, 1'b0, 1'b1, 8'd10, 32'd0, 4'h0);
        expect_q(1'b1, 3, 32'h1234, "t5_sparse_q3");
        b_step(n); chk("t5_sparse_stall", n, 32'd2);
        drain();
        chk("t5_overrun_pre", 32'(b_overrun), 32'd0);

        // START during STALL: overrun, step not re-executed
        b_port(1, 1'b1, 1'b0, 8'd12, 32'h4, 4'hF);
        b_step(n);
        b_port(1, 1'b1, 1'b1, 8'd12, 32'h5, 4'hF);
        b_port(3, 1'b0, 1'b1, 8'd12, 32'd0, 4'h0);
        expect_q(1'b1, 1, 32'h4, "t5_ovr_q1");
        expect_q(1'b1, 3, 32'h5, "t5_ovr_q3");
        b_start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 1;
        while (b_stall === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        b_idle();
        chk("t5_ovr_stall", n, 32'd2);
        chk("t5_ovr_flag", 32'(b_overrun), 32'd1);
        drain();

        // Reset in the 2nd SERVE cycle of a 3-access step
        b_port(0, 1'b1, 1'b0, 8'd20, 32'h0, 4'hF);
        b_port(1, 1'b1, 1'b0, 8'd21, 32'h0, 4'hF);
        b_port(2, 1'b1, 1'b0, 8'd22, 32'h0, 4'hF);
        b_step(n); chk("t6_pre_stall", n, 32'd3);
        b_port(0, 1'b1, 1'b0, 8'd20, 32'hA1, 4'hF);
        b_port(1, 1'b1, 1'b0, 8'd21, 32'hA2, 4'hF);
        b_port(2, 1'b1, 1'b0, 8'd22, 32'hA3, 4'hF);
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        b_idle();
        @(posedge clk); #1;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        chk("t6_stall", 32'(b_stall), 32'd0);
        chk("t6_overrun", 32'(b_overrun), 32'd0);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("t6_q%0d_zero", p), b_q[p*32 +: 32], 32'd0);
        end
        b_port(0, 1'b0, 1'b1, 8'd20, 32'd0, 4'h0);
        b_port(2, 1'b0, 1'b1, 8'd22, 32'd0, 4'h0);
        expect_q(1'b1, 0, 32'hA1, "t6_first_kept");
        expect_q(1'b1, 2, 32'h0, "t6_third_dropped");
        b_step(n); chk("t6_rd_stall", n, 32'd2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
